anton_neopixel_registers_mc: RTL and testbench

//  Multi-channel successor of the neopixel bus register file. One byte-wide bus slave holds a pixel RAM and a

---
 rtl/anton_neopixel_registers_mc_pkg.sv | 29 ++
 rtl/anton_neopixel_pixel_ram.sv | 40 ++++
 rtl/anton_neopixel_registers_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_anton_neopixel_registers_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_registers_mc_pkg.sv
// Shared register-map constants and macros for the multi-channel neopixel register file.
// Optional interrupt support (enable bit, sticky done flag, irq) is built when ANTON_NEOPIXEL_IRQ_EN is defined.
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH
`define CLOG2(x) $clog2(x)
`define BUFFER_END_DEFAULT 255
`endif

package anton_neopixel_registers_mc_pkg;
   localparam logic [1:0] OFF_MAX_LO = 2'd0;
   localparam logic [1:0] OFF_MAX_HI = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   localparam int CTRL_INIT  = 0;
   localparam int CTRL_LIMIT = 1;
   localparam int CTRL_RUN   = 2;
   localparam int CTRL_LOOP  = 3;
   localparam int CTRL_32BIT = 4;
   localparam int CTRL_IEN   = 5;

   localparam int STAT_STATE = 0;
   localparam int STAT_DONE  = 1;

   function automatic logic [7:0] pack_ctrl(input logic ien, input logic b32, input logic loop,
                                            input logic run, input logic limit, input logic init);
      return {2'b00, ien, b32, loop, run, limit, init};
   endfunction
endpackage

// File: rtl/anton_neopixel_pixel_ram.sv
// One channel of pixel storage: a bus write port plus registered bus and streamer read ports.
// Storage is sized to the full index range so every address is a legal array index.
module anton_neopixel_pixel_ram #(
   parameter int BUFFER_BITS = 8
)(
   input  logic                   busClk,
   input  logic                   busReset,
   input  logic                   wrEn,
   input  logic [BUFFER_BITS-1:0] wrAddr,
   input  logic [7:0]             wrData,
   input  logic                   busRdEn,
   input  logic [BUFFER_BITS-1:0] busRdAddr,
   output logic [7:0]             busRdData,
   input  logic [BUFFER_BITS-1:0] streamRdAddr,
   output logic [7:0]             streamRdData
);
   localparam int DEPTH = 1 << BUFFER_BITS;

   logic [7:0] mem_r [DEPTH];

   // Byte write port; the array itself carries no reset
   always_ff @(posedge busClk) begin
      if (wrEn) begin
         mem_r[wrAddr] <= wrData;
      end
   end

   // Registered read ports see the pre-write contents on a same-cycle collision
   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         busRdData    <= 8'h00;
         streamRdData <= 8'h00;
      end else begin
         if (busRdEn) begin
            busRdData <= mem_r[busRdAddr];
         end
         streamRdData <= mem_r[streamRdAddr];
      end
   end
endmodule

// File: rtl/anton_neopixel_registers_mc.sv
// Multi-channel neopixel bus slave: address decode, per-channel control/status registers and the read mux.
// Build option ANTON_NEOPIXEL_IRQ_EN adds the interrupt enable, sticky done flag with write-1-to-clear, and irq.
module anton_neopixel_registers_mc
   import anton_neopixel_registers_mc_pkg::*;
#(
   parameter int  CHANNELS    = 2,
   parameter int  BUFFER_END  = `BUFFER_END_DEFAULT,
   parameter int  ADDR_W      = 16,
   localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1),
   localparam int CH_BITS     = (`CLOG2(CHANNELS) > 1) ? `CLOG2(CHANNELS) : 1
)(
   input  logic                            busClk,
   input  logic                            busReset,
   input  logic [ADDR_W-1:0]               busAddr,
   input  logic [7:0]                      busDataIn,
   input  logic                            busWrite,
   input  logic                            busRead,
   output logic [7:0]                      busDataOut,
   output logic                            busReadValid,
   input  logic [CHANNELS*BUFFER_BITS-1:0] streamRdAddr,
   output logic [CHANNELS*8-1:0]           streamRdData,
   input  logic [CHANNELS-1:0]             streamSyncOf,
   input  logic [CHANNELS-1:0]             state,
   output logic [CHANNELS*13-1:0]          regMax,
   output logic [CHANNELS-1:0]             regCtrlInit,
   output logic [CHANNELS-1:0]             regCtrlLimit,
   output logic [CHANNELS-1:0]             regCtrlRun,
   output logic [CHANNELS-1:0]             regCtrlLoop,
   output logic [CHANNELS-1:0]             regCtrl32bit,
   output logic                            irq
);
   localparam int NCH_POW = 1 << CH_BITS;

   logic                   is_reg_s;
   logic                   reg_ok_s;
   logic                   pix_ok_s;
   logic [31:0]            reg_ch_s;
   logic [31:0]            pix_ch_s;
   logic [1:0]             reg_off_s;
   logic [BUFFER_BITS-1:0] pix_idx_s;
   logic [CHANNELS-1:0]    pix_we_s;
   logic [CHANNELS-1:0]    pix_re_s;
   logic [CHANNELS-1:0]    reg_we_s;
   logic [CHANNELS-1:0]    ien_s;
   logic [CHANNELS-1:0]    done_s;
   logic [7:0]             ch_byte_s [NCH_POW];
   logic [7:0]             ram_q_s [NCH_POW];
   logic [7:0]             reg_rd_s;

   logic [CHANNELS-1:0]    init_r;
   logic [CHANNELS-1:0]    limit_r;
   logic [CHANNELS-1:0]    run_r;
   logic [CHANNELS-1:0]    loop_r;
   logic [CHANNELS-1:0]    b32_r;
   logic [CHANNELS-1:0]    clr_pend_r;
   logic [12:0]            max_r [CHANNELS];
   logic [7:0]             reg_q_r;
   logic                   rd_valid_r;
   logic                   rd_pix_r;
   logic [CH_BITS-1:0]     rd_ch_r;

   // Address decode; the channel number spans all bits above the field, so high garbage is out of range
   always_comb begin
      is_reg_s  = busAddr[ADDR_W-1];
      reg_off_s = busAddr[1:0];
      reg_ch_s  = 32'(busAddr[ADDR_W-2:2]);
      pix_ch_s  = 32'(busAddr[ADDR_W-2:BUFFER_BITS]);
      pix_idx_s = busAddr[BUFFER_BITS-1:0];
      reg_ok_s  = is_reg_s && (reg_ch_s < 32'(CHANNELS));
      pix_ok_s  = !is_reg_s && (pix_ch_s < 32'(CHANNELS)) && (32'(pix_idx_s) <= 32'(BUFFER_END));
      for (int c = 0; c < CHANNELS; c++) begin
         pix_we_s[c] = busWrite && pix_ok_s && (pix_ch_s == 32'(c));
         pix_re_s[c] = busRead && pix_ok_s && (pix_ch_s == 32'(c));
         reg_we_s[c] = busWrite && reg_ok_s && (reg_ch_s == 32'(c)) && !clr_pend_r[c];
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      anton_neopixel_pixel_ram #(
         .BUFFER_BITS(BUFFER_BITS)
      ) u_pixel_ram (
         .busClk      (busClk),
         .busReset    (busReset),
         .wrEn        (pix_we_s[g]),
         .wrAddr      (pix_idx_s),
         .wrData      (busDataIn),
         .busRdEn     (pix_re_s[g]),
         .busRdAddr   (pix_idx_s),
         .busRdData   (ram_q_s[g]),
         .streamRdAddr(streamRdAddr[g*BUFFER_BITS +: BUFFER_BITS]),
         .streamRdData(streamRdData[g*8 +: 8])
      );
      assign regMax[g*13 +: 13] = max_r[g];
   end

   for (genvar g = CHANNELS; g < NCH_POW; g++) begin : g_pad
      assign ram_q_s[g] = 8'h00;
   end

   // Per-channel register byte selected by offset; unused mux slots read zero
   always_comb begin
      for (int c = 0; c < NCH_POW; c++) begin
         ch_byte_s[c] = 8'h00;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         case (reg_off_s)
            OFF_MAX_LO: ch_byte_s[c] = max_r[c][7:0];
            OFF_MAX_HI: ch_byte_s[c] = {3'b000, max_r[c][12:8]};
            OFF_CTRL:   ch_byte_s[c] = pack_ctrl(ien_s[c], b32_r[c], loop_r[c], run_r[c],
                                                 limit_r[c], init_r[c]);
            OFF_STATUS: ch_byte_s[c] = {6'b000000, done_s[c], state[c]};
            default:    ch_byte_s[c] = 8'h00;
         endcase
      end
   end

   assign reg_rd_s = reg_ok_s ? ch_byte_s[reg_ch_s[CH_BITS-1:0]] : 8'h00;

   // Read pipeline: register data is captured here, pixel data arrives from the RAM's own register
   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         rd_valid_r <= 1'b0;
         rd_pix_r   <= 1'b0;
         rd_ch_r    <= {CH_BITS{1'b0}};
         reg_q_r    <= 8'h00;
      end else begin
         rd_valid_r <= busRead;
         rd_pix_r   <= busRead && pix_ok_s;
         rd_ch_r    <= pix_ch_s[CH_BITS-1:0];
         reg_q_r    <= busRead ? reg_rd_s : 8'h00;
      end
   end

   assign busReadValid = rd_valid_r;
   assign busDataOut   = rd_pix_r ? ram_q_s[rd_ch_r] : reg_q_r;

   // Control and max registers; the cycle after an init write clears the channel and blocks its writes
   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         init_r     <= {CHANNELS{1'b0}};
         limit_r    <= {CHANNELS{1'b0}};
         run_r      <= {CHANNELS{1'b0}};
         loop_r     <= {CHANNELS{1'b0}};
         b32_r      <= {CHANNELS{1'b0}};
         clr_pend_r <= {CHANNELS{1'b0}};
         for (int c = 0; c < CHANNELS; c++) begin
            max_r[c] <= 13'd0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (clr_pend_r[c]) begin
               init_r[c]     <= 1'b0;
               limit_r[c]    <= 1'b0;
               run_r[c]      <= 1'b0;
               loop_r[c]     <= 1'b0;
               b32_r[c]      <= 1'b0;
               clr_pend_r[c] <= 1'b0;
            end else begin
               if (reg_we_s[c] && (reg_off_s == OFF_CTRL)) begin
                  init_r[c]     <= busDataIn[CTRL_INIT];
                  limit_r[c]    <= busDataIn[CTRL_LIMIT];
                  run_r[c]      <= busDataIn[CTRL_RUN];
                  loop_r[c]     <= busDataIn[CTRL_LOOP];
                  b32_r[c]      <= busDataIn[CTRL_32BIT];
                  clr_pend_r[c] <= busDataIn[CTRL_INIT];
               end
               if (reg_we_s[c] && (reg_off_s == OFF_MAX_LO)) begin
                  max_r[c][7:0] <= busDataIn;
               end
               if (reg_we_s[c] && (reg_off_s == OFF_MAX_HI)) begin
                  max_r[c][12:8] <= busDataIn[4:0];
               end
               // End of frame overrides a coincident bus write of run
               if (streamSyncOf[c]) begin
                  run_r[c] <= loop_r[c];
               end
            end
         end
      end
   end

   assign regCtrlInit  = init_r;
   assign regCtrlLimit = limit_r;
   assign regCtrlRun   = run_r;
   assign regCtrlLoop  = loop_r;
   assign regCtrl32bit = b32_r;

`ifdef ANTON_NEOPIXEL_IRQ_EN
   logic [CHANNELS-1:0] ien_r;
   logic [CHANNELS-1:0] done_r;

   // Interrupt enable and sticky done flag: sync set beats W1C, init clear beats sync
   always_ff @(posedge busClk or posedge busReset) begin
      if (busReset) begin
         ien_r  <= {CHANNELS{1'b0}};
         done_r <= {CHANNELS{1'b0}};
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (clr_pend_r[c]) begin
               ien_r[c]  <= 1'b0;
               done_r[c] <= 1'b0;
            end else begin
               if (reg_we_s[c] && (reg_off_s == OFF_CTRL)) begin
                  ien_r[c] <= busDataIn[CTRL_IEN];
               end
               if (reg_we_s[c] && (reg_off_s == OFF_STATUS) && busDataIn[STAT_DONE]) begin
                  done_r[c] <= 1'b0;
               end
               if (streamSyncOf[c]) begin
                  done_r[c] <= 1'b1;
               end
            end
         end
      end
   end

   assign ien_s  = ien_r;
   assign done_s = done_r;
   assign irq    = |(done_r & ien_r);
`else
   assign ien_s  = {CHANNELS{1'b0}};
   assign done_s = {CHANNELS{1'b0}};
   assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_anton_neopixel_registers_mc.sv
// Directed bench for anton_neopixel_registers_mc: 2 channels, 100-byte buffers (7-bit index).
// Status/irq expectations follow whether ANTON_NEOPIXEL_IRQ_EN is defined.
module tb_anton_neopixel_registers_mc;
   localparam int CH = 2;
   localparam int BE = 99;
   localparam int AW = 16;
   localparam int BB = 7;

   logic            busClk = 1'b0;
   logic            busReset;
   logic [AW-1:0]   busAddr;
   logic [7:0]      busDataIn;
   logic            busWrite;
   logic            busRead;
   logic [7:0]      busDataOut;
   logic            busReadValid;
   logic [CH*BB-1:0] streamRdAddr;
   logic [CH*8-1:0] streamRdData;
   logic [CH-1:0]   streamSyncOf;
   logic [CH-1:0]   state;
   logic [CH*13-1:0] regMax;
   logic [CH-1:0]   regCtrlInit;
   logic [CH-1:0]   regCtrlLimit;
   logic [CH-1:0]   regCtrlRun;
   logic [CH-1:0]   regCtrlLoop;
   logic [CH-1:0]   regCtrl32bit;
   logic            irq;

   int errors = 0;
   int checks = 0;

   anton_neopixel_registers_mc #(
      .CHANNELS  (CH),
      .BUFFER_END(BE),
      .ADDR_W    (AW)
   ) dut (
      .busClk      (busClk),
      .busReset    (busReset),
      .busAddr     (busAddr),
      .busDataIn   (busDataIn),
      .busWrite    (busWrite),
      .busRead     (busRead),
      .busDataOut  (busDataOut),
      .busReadValid(busReadValid),
      .streamRdAddr(streamRdAddr),
      .streamRdData(streamRdData),
      .streamSyncOf(streamSyncOf),
      .state       (state),
      .regMax      (regMax),
      .regCtrlInit (regCtrlInit),
      .regCtrlLimit(regCtrlLimit),
      .regCtrlRun  (regCtrlRun),
      .regCtrlLoop (regCtrlLoop),
      .regCtrl32bit(regCtrl32bit),
      .irq         (irq)
   );

   always #5 busClk = ~busClk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge busClk);
      busAddr   = a;
      busDataIn = d;
      busWrite  = 1'b1;
      @(negedge busClk);
      busWrite  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
      @(negedge busClk);
      busAddr = a;
      busRead = 1'b1;
      @(negedge busClk);
      busRead = 1'b0;
      check_eq({tag, "_valid"}, {31'd0, busReadValid}, 32'd1);
      check_eq(tag, {24'd0, busDataOut}, {24'd0, exp});
      @(negedge busClk);
      check_eq({tag, "_pulse"}, {31'd0, busReadValid}, 32'd0);
   endtask

   task automatic pulse_sync(input logic [CH-1:0] m);
      @(negedge busClk);
      streamSyncOf = m;
      @(negedge busClk);
      streamSyncOf = 2'b00;
   endtask

   initial begin
      busReset     = 1'b1;
      busAddr      = 16'h0000;
      busDataIn    = 8'h00;
      busWrite     = 1'b0;
      busRead      = 1'b0;
      streamRdAddr = 14'd0;
      streamSyncOf = 2'b00;
      state        = 2'b00;
      repeat (3) @(negedge busClk);
      check_eq("rst_valid", {31'd0, busReadValid}, 32'd0);
      check_eq("rst_dout", {24'd0, busDataOut}, 32'd0);
      check_eq("rst_stream", {16'd0, streamRdData}, 32'd0);
      check_eq("rst_max", {6'd0, regMax}, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      busReset = 1'b0;

      rd_chk("ch1_ctrl_rst", 16'h8006, 8'h00);

      // Pixel space: ch0 and ch1 index 7, plus index boundary
      bus_write(16'h0007, 8'h3C);
      bus_write(16'h0087, 8'hA5);
      streamRdAddr = {7'd7, 7'd7};
      @(negedge busClk);
      check_eq("stream_ch1", {24'd0, streamRdData[15:8]}, 32'hA5);
      check_eq("stream_ch0", {24'd0, streamRdData[7:0]}, 32'h3C);
      rd_chk("pix_ch1_7", 16'h0087, 8'hA5);
      rd_chk("pix_ch0_7", 16'h0007, 8'h3C);
      bus_write(16'h0063, 8'h5A);
      rd_chk("pix_idx99", 16'h0063, 8'h5A);
      bus_write(16'h0064, 8'h77);
      rd_chk("pix_idx100", 16'h0064, 8'h00);

      // Same-cycle read and write of one byte returns the old value
      @(negedge busClk);
      busAddr = 16'h0087; busDataIn = 8'h11; busWrite = 1'b1; busRead = 1'b1;
      @(negedge busClk);
      busWrite = 1'b0; busRead = 1'b0;
      check_eq("rdwr_valid", {31'd0, busReadValid}, 32'd1);
      check_eq("rdwr_old", {24'd0, busDataOut}, 32'hA5);
      rd_chk("rdwr_new", 16'h0087, 8'h11);

      // Stream port sees old data on the write cycle, new data after
      @(negedge busClk);
      busAddr = 16'h0087; busDataIn = 8'h22; busWrite = 1'b1;
      @(negedge busClk);
      busWrite = 1'b0;
      check_eq("stream_old", {24'd0, streamRdData[15:8]}, 32'h11);
      @(negedge busClk);
      check_eq("stream_new", {24'd0, streamRdData[15:8]}, 32'h22);

      // Max register
      bus_write(16'h8000, 8'h34);
      bus_write(16'h8001, 8'hFF);
      check_eq("max_ch0", {19'd0, regMax[12:0]}, 32'h1F34);
      rd_chk("max_hi", 16'h8001, 8'h1F);

      // Run/loop behaviour on end of frame
      bus_write(16'h8002, 8'h0C);
      check_eq("run_set", {31'd0, regCtrlRun[0]}, 32'd1);
      pulse_sync(2'b01);
      check_eq("run_loop", {31'd0, regCtrlRun[0]}, 32'd1);
      bus_write(16'h8002, 8'h04);
      pulse_sync(2'b01);
      check_eq("run_stop", {31'd0, regCtrlRun[0]}, 32'd0);
      rd_chk("ctrl_after", 16'h8002, 8'h00);
`ifdef ANTON_NEOPIXEL_IRQ_EN
      rd_chk("status_done", 16'h8003, 8'h02);
      state = 2'b01;
      rd_chk("status_busy", 16'h8003, 8'h03);
`else
      rd_chk("status_done", 16'h8003, 8'h00);
      state = 2'b01;
      rd_chk("status_busy", 16'h8003, 8'h01);
`endif
      state = 2'b00;

      // Init clears ch0 one cycle later and blocks that cycle's writes
      bus_write(16'h8006, 8'h1E);
      @(negedge busClk);
      busAddr = 16'h8002; busDataIn = 8'h21; busWrite = 1'b1;
      @(negedge busClk);
      check_eq("init_loaded", {31'd0, regCtrlInit[0]}, 32'd1);
      busAddr = 16'h8000; busDataIn = 8'h99;
      @(negedge busClk);
      busWrite = 1'b0;
      check_eq("init_clear", {31'd0, regCtrlInit[0]}, 32'd0);
      rd_chk("init_ctrl", 16'h8002, 8'h00);
      rd_chk("init_status", 16'h8003, 8'h00);
      check_eq("init_max", {19'd0, regMax[12:0]}, 32'h1F34);
      rd_chk("init_ch1", 16'h8006, 8'h1E);

      // Sync wins for run against a coincident ctrl write; the write sets the rest
      @(negedge busClk);
      busAddr = 16'h8006; busDataIn = 8'h0A; busWrite = 1'b1; streamSyncOf = 2'b10;
      @(negedge busClk);
      busWrite = 1'b0; streamSyncOf = 2'b00;
      rd_chk("sync_vs_wr", 16'h8006, 8'h0E);

`ifdef ANTON_NEOPIXEL_IRQ_EN
      bus_write(16'h8002, 8'h20);
      check_eq("irq_idle", {31'd0, irq}, 32'd0);
      pulse_sync(2'b01);
      check_eq("irq_set", {31'd0, irq}, 32'd1);
      bus_write(16'h8003, 8'h02);
      check_eq("irq_w1c", {31'd0, irq}, 32'd0);
      @(negedge busClk);
      busAddr = 16'h8003; busDataIn = 8'h02; busWrite = 1'b1; streamSyncOf = 2'b01;
      @(negedge busClk);
      busWrite = 1'b0; streamSyncOf = 2'b00;
      check_eq("irq_set_wins", {31'd0, irq}, 32'd1);
`else
      bus_write(16'h8002, 8'h20);
      rd_chk("ien_ignored", 16'h8002, 8'h00);
      pulse_sync(2'b01);
      check_eq("irq_tied", {31'd0, irq}, 32'd0);
`endif

      // Out-of-range channels
      bus_write(16'h8008, 8'h55);
      rd_chk("reg_ch2", 16'h8008, 8'h00);
      rd_chk("reg_ch0_keep", 16'h8000, 8'h34);
      rd_chk("pix_ch2", 16'h0107, 8'h00);

      // Reset in the middle of a read
      @(negedge busClk);
      busAddr = 16'h0087; busRead = 1'b1;
      @(posedge busClk);
      #2;
      check_eq("mid_valid_pre", {31'd0, busReadValid}, 32'd1);
      busReset = 1'b1;
      #1;
      check_eq("mid_valid", {31'd0, busReadValid}, 32'd0);
      check_eq("mid_dout", {24'd0, busDataOut}, 32'd0);
      check_eq("mid_stream", {16'd0, streamRdData}, 32'd0);
      check_eq("mid_max", {6'd0, regMax}, 32'd0);
      check_eq("mid_run", {30'd0, regCtrlRun}, 32'd0);
      @(negedge busClk);
      busRead = 1'b0;
      @(negedge busClk);
      busReset = 1'b0;
      rd_chk("post_rst_ram", 16'h0087, 8'h22);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
